// File: rtl/uart_rx_pkg.sv
// Frame-format helpers shared by the UART receiver and its transmit partner,
// so both sides derive bit counts from the same definitions.
package uart_rx_pkg;

  localparam int unsigned STATE_W = 3;

  // Error flags accumulated while a frame is in flight
  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_err_t;

  function automatic int unsigned stop_count(input int unsigned two_stop);
    return (two_stop != 0) ? 2 : 1;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input int unsigned parity,
                                             input int unsigned two_stop);
    return 1 + data_width + ((parity != 0) ? 1 : 0) + stop_count(two_stop);
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_bit.sv
// Two-flop synchronizer for a single asynchronous input, reset to RESET_VAL.
module uart_rx_sync_bit #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first data, optional parity,
// one or two stop bits; presents one word with error flags per frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PARITY        = 1,
  parameter int unsigned PARITY_ODD    = 0,
  parameter int unsigned TWO_STOP_BITS = 1,
  parameter int unsigned PERIOD        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int unsigned DLY_W     = $clog2(PERIOD);
  localparam int unsigned CNT_W     = cnt_width(DATA_WIDTH);
  localparam int unsigned STOP_BITS = stop_count(TWO_STOP_BITS);

  localparam logic [DLY_W-1:0] HALF_LOAD = DLY_W'(PERIOD / 2 - 1);
  localparam logic [DLY_W-1:0] FULL_LOAD = DLY_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  logic [STATE_W-1:0]    state_q, state_n;
  logic [DLY_W-1:0]      delay_q, delay_n;
  logic [CNT_W-1:0]      bit_q, bit_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  rx_err_t               err_q, err_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n, perr_n, ferr_n, busy_n;
  logic                  s_c, s_prev_q;
  logic                  start_edge_c, tick_c, exp_par_c;

  uart_rx_sync_bit #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (s_c)
  );

  assign start_edge_c = !s_c && s_prev_q;
  assign tick_c       = (delay_q == '0);
  assign exp_par_c    = (PARITY_ODD != 0) ? ~^shift_q : ^shift_q;

  // Next-state, counters, shift register and output staging
  always_comb begin
    state_n = state_q;
    delay_n = delay_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    err_n   = err_q;
    data_n  = ov_data;
    valid_n = 1'b0;
    perr_n  = o_parity_err;
    ferr_n  = o_frame_err;

    if (state_q != ST_IDLE && !tick_c) delay_n = delay_q - DLY_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          delay_n = HALF_LOAD;
          err_n   = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (s_c) begin
            state_n = ST_IDLE;
          end else begin
            delay_n = FULL_LOAD;
            bit_n   = '0;
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_n                 = shift_q >> 1;
          shift_n[DATA_WIDTH-1]   = s_c;
          delay_n                 = FULL_LOAD;
          if (bit_q == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          err_n.parity_err = (s_c != exp_par_c);
          delay_n          = FULL_LOAD;
          bit_n            = '0;
          state_n          = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          err_n.frame_err = err_q.frame_err | ~s_c;
          // Leave at mid-stop so a back-to-back start edge is still caught
          if (bit_q == LAST_STOP) begin
            state_n = ST_IDLE;
            valid_n = 1'b1;
            data_n  = shift_q;
            perr_n  = (PARITY != 0) && err_q.parity_err;
            ferr_n  = err_n.frame_err;
          end else begin
            delay_n = FULL_LOAD;
            bit_n   = bit_q + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      s_prev_q     <= 1'b1;
      delay_q      <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      err_q        <= '0;
      ov_data      <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_n;
      s_prev_q     <= s_c;
      delay_q      <= delay_n;
      bit_q        <= bit_n;
      shift_q      <= shift_n;
      err_q        <= err_n;
      ov_data      <= data_n;
      o_valid      <= valid_n;
      o_parity_err <= perr_n;
      o_frame_err  <= ferr_n;
      o_busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8E2 at 16 clocks/bit, plus 8N1 at 4 clocks/bit.
module tb_uart_rx;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    bit         flip;
    logic [1:0] stop_low;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rec_t qa[$];
  rec_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_WIDTH(8), .PARITY(1), .PARITY_ODD(0), .TWO_STOP_BITS(1), .PERIOD(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_a), .ov_data(data_a), .o_valid(valid_a),
    .o_parity_err(pe_a), .o_frame_err(fe_a), .o_busy(busy_a)
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY(0), .PARITY_ODD(0), .TWO_STOP_BITS(0), .PERIOD(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_b), .ov_data(data_b), .o_valid(valid_b),
    .o_parity_err(pe_b), .o_frame_err(fe_b), .o_busy(busy_b)
  );

  // Record every valid pulse with the cycle it was seen in
  always @(negedge clk) begin
    if (valid_a) qa.push_back('{data_a, pe_a, fe_a, cyc});
    if (valid_b) qb.push_back('{data_b, pe_b, fe_b, cyc});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  // sel=0: 8 data, even parity, 2 stop, 16 clk/bit; sel=1: 8N1, 4 clk/bit
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit flip,
                            input logic [1:0] stop_low);
    logic [11:0] bits;
    int n;
    int per;
    per  = sel ? 4 : 16;
    bits = '1;
    n    = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i]; n++;
    end
    if (!sel) begin
      bits[n] = (^d) ^ flip; n++;
    end
    bits[n] = ~stop_low[0]; n++;
    if (!sel) begin
      bits[n] = ~stop_low[1]; n++;
    end
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      idle(per);
    end
    drive(sel, 1'b1);
  endtask

  task automatic expect_frame(input bit sel, input string name, input logic [7:0] d,
                              input logic pe, input logic fe, output rec_t r);
    int n;
    r = '{default: 0};
    n = sel ? qb.size() : qa.size();
    chk({name, "_count"}, n, 1);
    if (n > 0) begin
      if (sel) r = qb[0];
      else r = qa[0];
      chk({name, "_data"}, r.d, d);
      chk({name, "_parity_err"}, r.pe, pe);
      chk({name, "_frame_err"}, r.fe, fe);
    end
    if (sel) qb.delete();
    else qa.delete();
  endtask

  initial begin
    rec_t r;
    int   t0;
    vec_t vecs[6];
    logic [7:0] b2b[3];

    vecs[0] = '{8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 2'b00, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 2'b00, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0};
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_parity_err", pe_a, 0);
    chk("rst_frame_err", fe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    idle(20);

    // Single frame with latency from line fall (2-cycle sync + 8 + 11*16 + 1)
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 2'b00);
    idle(32);
    expect_frame(0, "t1", 8'hA5, 1'b0, 1'b0, r);
    chk("t1_latency", r.cyc - t0, 187);

    // Short low glitch is a false start
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    chk("t2_busy_high", busy_a, 1);
    idle(20);
    chk("t2_busy_low", busy_a, 0);
    chk("t2_no_valid", qa.size(), 0);
    send_frame(0, 8'h3C, 1'b0, 2'b00);
    idle(32);
    expect_frame(0, "t2_next", 8'h3C, 1'b0, 1'b0, r);

    foreach (vecs[i]) begin
      send_frame(0, vecs[i].d, vecs[i].flip, vecs[i].stop_low);
      idle(32);
      expect_frame(0, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe, r);
    end

    // Break: line stuck low for 40 bit times gives exactly one errored frame
    rx_a = 1'b0;
    idle(640);
    expect_frame(0, "t4_break", 8'h00, 1'b0, 1'b1, r);
    rx_a = 1'b1;
    idle(32);
    send_frame(0, 8'h7E, 1'b0, 2'b00);
    idle(32);
    expect_frame(0, "t4_recover", 8'h7E, 1'b0, 1'b0, r);

    // Back-to-back frames without idle gap
    for (int i = 0; i < 3; i++) send_frame(0, b2b[i], 1'b0, 2'b00);
    idle(32);
    chk("t5_count", qa.size(), 3);
    if (qa.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t5_data%0d", i), qa[i].d, b2b[i]);
        chk($sformatf("t5_err%0d", i), {qa[i].pe, qa[i].fe}, 0);
      end
      chk("t5_spacing", qa[1].cyc - qa[0].cyc, 192);
    end
    qa.delete();

    // Async reset during data bit 3 of 0x81
    rx_a = 1'b0;
    idle(16);
    for (int i = 0; i < 3; i++) begin
      rx_a = (i == 0);
      idle(16);
    end
    rx_a = 1'b0;
    idle(8);
    chk("t6_busy_before", busy_a, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", data_a, 0);
    chk("t6_rst_valid", valid_a, 0);
    chk("t6_rst_flags", {pe_a, fe_a}, 0);
    chk("t6_rst_busy", busy_a, 0);
    rx_a = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);
    chk("t6_no_partial", qa.size(), 0);
    send_frame(0, 8'h81, 1'b0, 2'b00);
    idle(32);
    expect_frame(0, "t6_after", 8'h81, 1'b0, 1'b0, r);

    // 8N1 at 4 clocks/bit: latency 2 + 2 + 9*4 + 1
    t0 = cyc;
    send_frame(1, 8'hA5, 1'b0, 2'b00);
    idle(8);
    expect_frame(1, "b1", 8'hA5, 1'b0, 1'b0, r);
    chk("b1_latency", r.cyc - t0, 41);

    for (int i = 0; i < 3; i++) send_frame(1, b2b[i], 1'b0, 2'b00);
    idle(8);
    chk("b5_count", qb.size(), 3);
    if (qb.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b5_data%0d", i), qb[i].d, b2b[i]);
        chk($sformatf("b5_err%0d", i), {qb[i].pe, qb[i].fe}, 0);
      end
      chk("b5_spacing", qb[2].cyc - qb[1].cyc, 40);
    end
    qb.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
